// File: rtl/octree_fetch_pkg.sv
// Shared types and constants for the octree node-fetch arbiter.
package octree_fetch_pkg;

  localparam int ROM_DEPTH_DEFAULT = 38;
  localparam int MAX_REQ           = 8;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slots are sized for the largest supported requester count so the
  // struct stays independent of the NUM_REQ parameter.
  localparam int SLOT_ID_W = id_width(MAX_REQ);

  // One ROM port's worth of in-flight bookkeeping.
  typedef struct packed {
    logic                 vld;
    logic [SLOT_ID_W-1:0] id;
    logic                 err;
  } port_slot_t;

endpackage

// File: rtl/octree_fetch_arbiter_rr_pick2.sv
// Dual-pick round-robin encoder: the first two eligible requesters found
// scanning upward from rr_ptr (wrapping) are assigned to port 1 then port 2.
module rr_pick2
  import octree_fetch_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   eligible,
  input  logic [SLOT_ID_W-1:0] rr_ptr,
  output logic                 p1_vld,
  output logic [SLOT_ID_W-1:0] p1_id,
  output logic                 p2_vld,
  output logic [SLOT_ID_W-1:0] p2_id,
  output logic [SLOT_ID_W-1:0] next_ptr
);

  logic [2*NUM_REQ-1:0] doubled;

  // Rotate the eligible vector so bit k is requester (rr_ptr + k) mod NUM_REQ.
  assign doubled = {eligible, eligible} >> rr_ptr;

  // Scan the rotated vector, take the first two hits, then advance the pointer.
  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    p1_vld   = 1'b0;
    p1_id    = '0;
    p2_vld   = 1'b0;
    p2_id    = '0;
    next_ptr = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (doubled[k]) begin
        if (!p1_vld) begin
          p1_vld = 1'b1;
          p1_id  = SLOT_ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end else if (!p2_vld) begin
          p2_vld = 1'b1;
          p2_id  = SLOT_ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
    if (p2_vld) begin
      next_ptr = SLOT_ID_W'((int'(p2_id) + 1) % NUM_REQ);
    end else if (p1_vld) begin
      next_ptr = SLOT_ID_W'((int'(p1_id) + 1) % NUM_REQ);
    end
  end

endmodule

// File: rtl/octree_fetch_arbiter.sv
// Shares a dual-read-port octree node ROM between NUM_REQ traversal units:
// up to two grants per cycle, responses routed back one cycle later.
module octree_fetch_arbiter
  import octree_fetch_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = ROM_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [NUM_REQ-1:0]            rsp_err,
  output logic [ADDRESS_WIDTH-1:0]      rom_addr1,
  output logic [ADDRESS_WIDTH-1:0]      rom_addr2,
  output logic                          rom_ren,
  input  logic [DATA_WIDTH-1:0]         rom_dout1,
  input  logic [DATA_WIDTH-1:0]         rom_dout2
);

  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(ROM_DEPTH);

  logic [NUM_REQ-1:0]            pend;
  logic [NUM_REQ-1:0]            eligible;
  logic [SLOT_ID_W-1:0]          rr_ptr;
  logic [SLOT_ID_W-1:0]          rr_next;
  logic                          pick1_vld;
  logic                          pick2_vld;
  logic [SLOT_ID_W-1:0]          pick1_id;
  logic [SLOT_ID_W-1:0]          pick2_id;
  logic [ADDRESS_WIDTH-1:0]      sel_addr1;
  logic [ADDRESS_WIDTH-1:0]      sel_addr2;
  port_slot_t                    p1_d;
  port_slot_t                    p2_d;
  port_slot_t                    p1_q;
  port_slot_t                    p2_q;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_d;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_q;

  // A requester is pending exactly while its response slot is in flight.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = (p1_q.vld && p1_q.id == SLOT_ID_W'(i)) ||
                (p2_q.vld && p2_q.id == SLOT_ID_W'(i));
    end
    eligible = req_valid & ~pend;
  end

  rr_pick2 #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .p1_vld   (pick1_vld),
    .p1_id    (pick1_id),
    .p2_vld   (pick2_vld),
    .p2_id    (pick2_id),
    .next_ptr (rr_next)
  );

  // Select granted addresses, raise ready, and drive the ROM ports;
  // out-of-range addresses still occupy their port but read word 0.
  always_comb begin
    sel_addr1 = '0;
    sel_addr2 = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick1_vld && pick1_id == SLOT_ID_W'(i)) begin
        sel_addr1    = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        req_ready[i] = 1'b1;
      end
      if (pick2_vld && pick2_id == SLOT_ID_W'(i)) begin
        sel_addr2    = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        req_ready[i] = 1'b1;
      end
    end
    p1_d      = '{vld: pick1_vld, id: pick1_id, err: pick1_vld && (sel_addr1 >= DEPTH_A)};
    p2_d      = '{vld: pick2_vld, id: pick2_id, err: pick2_vld && (sel_addr2 >= DEPTH_A)};
    rom_addr1 = (p1_d.vld && !p1_d.err) ? sel_addr1 : '0;
    rom_addr2 = (p2_d.vld && !p2_d.err) ? sel_addr2 : '0;
    rom_ren   = pick1_vld | pick2_vld;
  end

  // Route the ROM words of last cycle's grants back to their requesters;
  // other slices present the last word they delivered.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    data_d    = data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p1_q.vld && p1_q.id == SLOT_ID_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_err[i]   = p1_q.err;
        data_d[i*DATA_WIDTH +: DATA_WIDTH] = p1_q.err ? '0 : rom_dout1;
      end else if (p2_q.vld && p2_q.id == SLOT_ID_W'(i)) begin
        rsp_valid[i] = 1'b1;
        rsp_err[i]   = p2_q.err;
        data_d[i*DATA_WIDTH +: DATA_WIDTH] = p2_q.err ? '0 : rom_dout2;
      end
    end
    rsp_data = data_d;
  end

  // Pointer, pipeline slots and per-requester data hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data hold register is reset too, because its contents are
      // visible on rsp_data and must read as zero straight out of reset.
      rr_ptr <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      rr_ptr <= rr_next;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_octree_fetch_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a cycle-level reference model of the arbitration rules.
module tb_octree_fetch_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 38;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_err;
  logic [AW-1:0]   rom_addr1;
  logic [AW-1:0]   rom_addr2;
  logic            rom_ren;
  logic [DW-1:0]   rom_dout1;
  logic [DW-1:0]   rom_dout2;

  logic [DW-1:0]   rom_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int              m_rr;
  logic [N-1:0]    m_pend;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    last_grant;

  octree_fetch_arbiter #(
    .NUM_REQ       (N),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .ROM_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rom_addr1 (rom_addr1),
    .rom_addr2 (rom_addr2),
    .rom_ren   (rom_ren),
    .rom_dout1 (rom_dout1),
    .rom_dout2 (rom_dout2)
  );

  always #5 clk = ~clk;

  // Dual-port ROM with registered read and read enable.
  always @(posedge clk) begin
    if (rom_ren) begin
      rom_dout1 <= (rom_addr1 < DEPTH) ? rom_mem[rom_addr1] : '0;
      rom_dout2 <= (rom_addr2 < DEPTH) ? rom_mem[rom_addr2] : '0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
  endtask

  // One clock cycle: check the grant side mid-cycle, then the response side
  // just after the edge, advancing the model in between.
  task automatic cycle();
    int            g1;
    int            g2;
    int            idx;
    logic [N-1:0]  gm;
    logic [N-1:0]  e_err;
    logic [AW-1:0] ea1;
    logic [AW-1:0] ea2;
    logic [AW-1:0] a;
    @(negedge clk);
    g1 = -1;
    g2 = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (req_valid[idx] && !m_pend[idx]) begin
        if (g1 < 0) g1 = idx;
        else if (g2 < 0) g2 = idx;
      end
    end
    gm = '0;
    if (g1 >= 0) gm[g1] = 1'b1;
    if (g2 >= 0) gm[g2] = 1'b1;
    ea1 = (g1 >= 0 && addr_of(g1) < DEPTH) ? addr_of(g1) : '0;
    ea2 = (g2 >= 0 && addr_of(g2) < DEPTH) ? addr_of(g2) : '0;
    check("req_ready", 128'(req_ready), 128'(gm));
    check("rom_ren", 128'(rom_ren), 128'(|gm));
    check("rom_addr1", 128'(rom_addr1), 128'(ea1));
    check("rom_addr2", 128'(rom_addr2), 128'(ea2));
    @(posedge clk);
    #1;
    m_pend = gm;
    if (g2 >= 0) m_rr = (g2 + 1) % N;
    else if (g1 >= 0) m_rr = (g1 + 1) % N;
    e_err = '0;
    for (int i = 0; i < N; i++) begin
      if (gm[i]) begin
        a = addr_of(i);
        e_err[i] = (a >= DEPTH);
        m_data[i*DW +: DW] = (a >= DEPTH) ? '0 : rom_mem[a];
      end
    end
    check("rsp_valid", 128'(rsp_valid), 128'(gm));
    check("rsp_err", 128'(rsp_err), 128'(e_err));
    check("rsp_data", 128'(rsp_data), 128'(m_data));
    last_grant = gm;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    #1;
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    m_rr       = 0;
    m_pend     = '0;
    m_data     = '0;
    last_grant = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 32'hA5A5_0000 | 32'(i);

    // Single request; the re-issued request is held off by pend for a cycle.
    apply_reset();
    set_req(0, 1'b1, 32'd5);
    cycle();
    check("single_data", 128'(rsp_data[DW-1:0]), 128'(32'hA5A5_0005));
    set_req(0, 1'b1, 32'd6);
    cycle();
    cycle();
    set_req(0, 1'b0, 32'd0);
    cycle();

    // All four requesting continuously: {0,1},{2,3},{0,1},{2,3}.
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 3));
    for (int c = 0; c < 4; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (last_grant[i]) set_req(i, 1'b1, 32'((c * 7 + i * 5) % DEPTH));
    end
    req_valid = '0;
    cycle();

    // Fairness: pointer moved to 2 by a {0,1} grant, then requesters 3 and 1.
    apply_reset();
    set_req(0, 1'b1, 32'd1);
    set_req(1, 1'b1, 32'd2);
    cycle();
    req_valid = '0;
    cycle();
    set_req(1, 1'b1, 32'd10);
    set_req(3, 1'b1, 32'd20);
    cycle();
    check("fair_grant", 128'(last_grant), 128'(4'b1010));
    req_valid = '0;
    cycle();

    // Out of range next to the last valid word.
    apply_reset();
    set_req(0, 1'b1, 32'd37);
    set_req(2, 1'b1, 32'd38);
    cycle();
    check("oor_err2", 128'(rsp_err[2]), 128'(1'b1));
    req_valid = '0;

    // Idle stretch, then all request to show the pointer kept its place.
    for (int c = 0; c < 5; c++) cycle();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i + 30));
    cycle();
    req_valid = '0;
    cycle();

    // Reset while responses are on the outputs.
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i + 11));
    cycle();
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i + 21));
    cycle();
    check("post_rst_grant", 128'(last_grant), 128'(4'b0011));
    req_valid = '0;
    cycle();

    // Random traffic; requests stay stable until granted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant[i])
          set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 7)));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/octree_fetch_arbiter.md
Name: octree_fetch_arbiter

Overview:
Shares the dual-read-port octree node ROM (38 words, 1-cycle registered read, read enable) between NUM_REQ ray-traversal units. Each cycle it picks up to two pending node-fetch requests by round-robin and maps them onto ROM port 1 and port 2. One cycle later it routes each read word back to the requester that issued it. It sits between the traversal units and the octree ROM and is the only master of the ROM address, read-enable and data ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDRESS_WIDTH, 32, ROM address width
DATA_WIDTH, 32, ROM word width
ROM_DEPTH, 38, valid ROM words; addresses at or above this are out of range

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester fetch request
req_addr  in  NUM_REQ*ADDRESS_WIDTH  flattened node address; slice i belongs to requester i
req_ready  out  NUM_REQ  request accepted this cycle (combinational)
rsp_valid  out  NUM_REQ  registered; response for requester i this cycle
rsp_data  out  NUM_REQ*DATA_WIDTH  flattened node word
rsp_err  out  NUM_REQ  response was for an out-of-range address
rom_addr1  out  ADDRESS_WIDTH  ROM port 1 address
rom_addr2  out  ADDRESS_WIDTH  ROM port 2 address
rom_ren  out  1  ROM read enable
rom_dout1  in  DATA_WIDTH  ROM port 1 data
rom_dout2  in  DATA_WIDTH  ROM port 2 data

Behaviour:
- Reset (async, rst=1): rr_ptr=0; pipeline valid flags = 0; rsp_valid=0, rsp_err=0, rsp_data=0. Requests in flight are dropped and no response is issued for them.
- Eligibility: eligible[i] = req_valid[i] & ~pend[i]. pend[i] is set in the cycle after requester i is granted and clears when its response is delivered. One outstanding request per requester.
- Pick in cycle T: scan eligible requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - First hit goes to port 1; second hit goes to port 2.
  - Zero hits: rom_ren=0, both rom addrs = 0.
  - One hit: port 2 idle, rom_addr2 = 0.
- req_ready[i]=1 exactly when i is granted in T. Requesters hold req_valid and req_addr stable until ready.
- rom_ren = any grant. Combinational from the grant.
- rr_ptr update at end of T, only if any grant: (index of last granted requester + 1) mod NUM_REQ. Otherwise unchanged.
- Out of range (req_addr >= ROM_DEPTH): the request is still granted and still consumes a port. The ROM address is forced to 0. The err flag is carried through the pipeline.
- Pipeline register at end of T captures p1_vld, p1_id, p1_err, p2_vld, p2_id, p2_err.
- Response in cycle T+1:
  - rsp_valid[p1_id] = 1, rsp_data slice = rom_dout1 (0 if err), rsp_err = p1_err.
  - Same for port 2 using rom_dout2.
  - Non-addressed slices: rsp_valid=0, rsp_err=0, data holds its last value.
- Latency: request accepted at T, response at T+1. The same requester may be granted again no earlier than T+2. Peak throughput is 2 fetches per cycle overall.
- Both ports never carry the same requester id in one cycle.
- Requester drops req_valid before ready (protocol violation): no grant is issued. Not checked.

Decomposition:
- Package octree_fetch_pkg:
  - ROM_DEPTH_DEFAULT = 38.
  - Function clog2-based id width.
  - typedef port_slot_t {vld, id, err}.
- Sub-module rr_pick2: combinational dual-pick round-robin encoder. Inputs: eligible vector and rr_ptr. Outputs: two valid/id pairs and the next pointer.
- Top level holds the registers, address muxing and response routing.

Test Plan:
- Single request: req_valid=4'b0001, addr=5, ROM[5]=0xA5A5_0005. Expect ready[0] in T, rom_addr1=5, rom_ren=1; rsp_valid=4'b0001 and data 0xA5A5_0005 in T+1; pend blocks a grant in T+1.
- All four requesting continuously after reset. Grants in successive cycles: {0,1}, {2,3}, {0,1}, {2,3}. Port 1 always carries the lower-rotation id. Two responses per cycle from T+1 onward.
- Round-robin fairness: req 1 and 3 only, with rr_ptr=2 initially. First grant is port1=3, port2=1, and rr_ptr then becomes 2.
- Out of range: requester 2 with addr=38 and requester 0 with addr=37 together. Expect rom_addr1=37 for id 0 and rom_addr2=0 for id 2. In T+1, rsp_err[2]=1 with data 0, and rsp_err[0]=0 with data ROM[37].
- Idle: no req_valid for 5 cycles. Expect rom_ren=0, rom addrs 0, rsp_valid=0, and rr_ptr unchanged.
- Reset mid-operation: assert rst asynchronously in the cycle after a grant. Expect rsp_valid=0 immediately and no stale response after release. The first post-reset grant starts from requester 0.
